// File: rtl/picorv_irq_ctrl.sv
// External interrupt controller: captures peripheral sources, tracks each source through
// IDLE -> PENDING -> IN_SERVICE and drives the core's 32-bit irq/eoi handshake.
module picorv_irq_ctrl #(
    parameter int NUM_SRC  = 8,
    parameter int IRQ_BASE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_i,
    output logic [31:0]          irq_o,
    input  logic [31:0]          eoi_i,
    input  logic                 cfg_we,
    input  logic                 cfg_re,
    input  logic [2:0]           cfg_addr,
    input  logic [31:0]          cfg_wdata,
    output logic [31:0]          cfg_rdata,
    output logic [2*NUM_SRC-1:0] dbg_state_o
);

    // Handshake: irq_o[IRQ_BASE+i] is held while source i is PENDING and enabled; the core
    // acks with a rising eoi bit (PENDING -> IN_SERVICE) and ends service with its fall.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_ENABLE    = 3'd0;
    localparam logic [2:0] ADDR_EDGE      = 3'd1;
    localparam logic [2:0] ADDR_PENDING   = 3'd2;
    localparam logic [2:0] ADDR_INSERVICE = 3'd3;
    localparam logic [2:0] ADDR_OVERFLOW  = 3'd4;

    state_t state_q [NUM_SRC];
    state_t state_d [NUM_SRC];

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] overflow_q, overflow_d;
    logic [NUM_SRC-1:0] repend_q, repend_d;
    logic [NUM_SRC-1:0] src_q, eoi_q;
    logic [31:0]        irq_q, irq_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] wdata_src, eoi_src, src_event, eoi_rise, eoi_fall;
    logic [NUM_SRC-1:0] w1c_pend, w1c_ovf, ovf_set, pend_vec, insvc_vec;

    logic unused_bits;
    assign unused_bits = ^{cfg_wdata, eoi_i};

    always_comb begin
        wdata_src = cfg_wdata[NUM_SRC-1:0];
        eoi_src   = eoi_i[IRQ_BASE +: NUM_SRC];
        src_event = (edge_q & src_i & ~src_q) | (~edge_q & src_i);
        eoi_rise  = eoi_src & ~eoi_q;
        eoi_fall  = ~eoi_src & eoi_q;
        w1c_pend  = (cfg_we && cfg_addr == ADDR_PENDING)  ? wdata_src : '0;
        w1c_ovf   = (cfg_we && cfg_addr == ADDR_OVERFLOW) ? wdata_src : '0;
    end

    always_comb begin
        repend_d = repend_q;
        ovf_set  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (src_event[i] || repend_q[i]) begin
                        state_d[i]  = ST_PENDING;
                        repend_d[i] = 1'b0;
                    end
                end
                ST_PENDING: begin
                    // A fresh event beats a software clear in the same cycle.
                    if (eoi_rise[i])
                        state_d[i] = ST_IN_SERVICE;
                    else if (w1c_pend[i] && !src_event[i])
                        state_d[i] = ST_IDLE;
                end
                ST_IN_SERVICE: begin
                    if (eoi_fall[i])
                        state_d[i] = ST_IDLE;
                    if (edge_q[i] && src_event[i]) begin
                        if (repend_q[i])
                            ovf_set[i] = 1'b1;
                        else
                            repend_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pend_vec  = '0;
        insvc_vec = '0;
        irq_d     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_vec[i]  = (state_q[i] == ST_PENDING);
            insvc_vec[i] = (state_q[i] == ST_IN_SERVICE);
            // Drops on the same edge that acks or clears the request.
            irq_d[IRQ_BASE + i] = (state_q[i] == ST_PENDING) && (state_d[i] == ST_PENDING)
                                  && enable_q[i];
        end

        enable_d   = (cfg_we && cfg_addr == ADDR_ENABLE) ? wdata_src : enable_q;
        edge_d     = (cfg_we && cfg_addr == ADDR_EDGE)   ? wdata_src : edge_q;
        overflow_d = (overflow_q & ~w1c_ovf) | ovf_set;

        rdata_d = '0;
        if (cfg_re) begin
            case (cfg_addr)
                ADDR_ENABLE:    rdata_d[NUM_SRC-1:0] = enable_q;
                ADDR_EDGE:      rdata_d[NUM_SRC-1:0] = edge_q;
                ADDR_PENDING:   rdata_d[NUM_SRC-1:0] = pend_vec;
                ADDR_INSERVICE: rdata_d[NUM_SRC-1:0] = insvc_vec;
                ADDR_OVERFLOW:  rdata_d[NUM_SRC-1:0] = overflow_q;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) state_q[i] <= ST_IDLE;
            enable_q   <= '0;
            edge_q     <= '0;
            overflow_q <= '0;
            repend_q   <= '0;
            src_q      <= '0;
            eoi_q      <= '0;
            irq_q      <= '0;
            rdata_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) state_q[i] <= state_d[i];
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            overflow_q <= overflow_d;
            repend_q   <= repend_d;
            src_q      <= src_i;
            eoi_q      <= eoi_src;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        dbg_state_o = '0;
        for (int i = 0; i < NUM_SRC; i++) dbg_state_o[2*i +: 2] = state_q[i];
    end

    assign irq_o     = irq_q;
    assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_picorv_irq_ctrl.sv
// Directed bench for picorv_irq_ctrl: a cycle table for the edge path and register port,
// plus hand sequences for repend/overflow, level+mask, W1C race, stray eoi and reset.
module tb_picorv_irq_ctrl;
    localparam int NUM_SRC  = 8;
    localparam int IRQ_BASE = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_SRC-1:0]   src_r;
    logic [31:0]          irq_o;
    logic [31:0]          eoi_r;
    logic                 cfg_we, cfg_re;
    logic [2:0]           cfg_addr;
    logic [31:0]          cfg_wdata;
    logic [31:0]          cfg_rdata;
    logic [2*NUM_SRC-1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    picorv_irq_ctrl #(.NUM_SRC(NUM_SRC), .IRQ_BASE(IRQ_BASE)) dut (
        .clk(clk), .reset(reset), .src_i(src_r), .irq_o(irq_o), .eoi_i(eoi_r),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_SRC-1:0] src;
        logic [31:0]        eoi;
        logic               we;
        logic               re;
        logic [2:0]         addr;
        logic [31:0]        wdata;
        logic [31:0]        exp_irq;
        logic               chk_rd;
        logic [31:0]        exp_rd;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic [NUM_SRC-1:0] src, logic [31:0] eoi, logic we, logic re,
                                logic [2:0] addr, logic [31:0] wdata, logic [31:0] exp_irq,
                                logic chk_rd, logic [31:0] exp_rd);
        vec_t v;
        v.src = src; v.eoi = eoi; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.exp_irq = exp_irq; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        cfg_re = 1'b1; cfg_addr = addr;
        tick();
        chk(name, cfg_rdata, exp);
        cfg_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Edge path on source 0, then register-port corner cases.
        vecs[0]  = mk(8'h00, 32'h0, 1, 0, 3'd0, 32'h1, 32'h0, 0, 32'h0);
        vecs[1]  = mk(8'h00, 32'h0, 1, 0, 3'd1, 32'h1, 32'h0, 0, 32'h0);
        vecs[2]  = mk(8'h01, 32'h0, 0, 1, 3'd2, 32'h0, 32'h0, 1, 32'h0);
        vecs[3]  = mk(8'h00, 32'h0, 0, 1, 3'd2, 32'h0, 32'h8, 1, 32'h1);
        vecs[4]  = mk(8'h00, 32'h8, 0, 1, 3'd3, 32'h0, 32'h0, 1, 32'h0);
        vecs[5]  = mk(8'h00, 32'h8, 0, 1, 3'd3, 32'h0, 32'h0, 1, 32'h1);
        vecs[6]  = mk(8'h00, 32'h0, 0, 1, 3'd3, 32'h0, 32'h0, 1, 32'h1);
        vecs[7]  = mk(8'h00, 32'h0, 0, 1, 3'd3, 32'h0, 32'h0, 1, 32'h0);
        vecs[8]  = mk(8'h00, 32'h0, 0, 1, 3'd2, 32'h0, 32'h0, 1, 32'h0);
        vecs[9]  = mk(8'h00, 32'h0, 1, 1, 3'd0, 32'hFFFF_FFFF, 32'h0, 1, 32'h1);
        vecs[10] = mk(8'h00, 32'h0, 0, 1, 3'd0, 32'h0, 32'h0, 1, 32'hFF);
        vecs[11] = mk(8'h00, 32'h0, 1, 1, 3'd5, 32'h1, 32'h0, 1, 32'h0);

        // Reset with all sources high.
        reset = 1'b1; src_r = '1; eoi_r = '0;
        cfg_we = 1'b0; cfg_re = 1'b1; cfg_addr = 3'd2; cfg_wdata = '0;
        repeat (3) tick();
        chk("reset_irq", irq_o, 32'h0);
        chk("reset_rdata", cfg_rdata, 32'h0);
        chk("reset_dbg", {16'h0, dbg_state}, 32'h0);
        reset = 1'b0; src_r = '0; cfg_re = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("reset_reg%0d", a));

        for (int v = 0; v < 12; v++) begin
            src_r = vecs[v].src; eoi_r = vecs[v].eoi;
            cfg_we = vecs[v].we; cfg_re = vecs[v].re;
            cfg_addr = vecs[v].addr; cfg_wdata = vecs[v].wdata;
            tick();
            chk($sformatf("vec%0d_irq", v), irq_o, vecs[v].exp_irq);
            if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), cfg_rdata, vecs[v].exp_rd);
        end
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_wdata = '0; src_r = '0; eoi_r = '0;

        // Repend and overflow on source 0 (edge mode, enabled).
        src_r = 8'h01; tick();
        src_r = 8'h00; tick();
        chk("rp_irq_pend", irq_o, 32'h8);
        eoi_r = 32'h8; tick();
        chk("rp_irq_ack", irq_o, 32'h0);
        src_r = 8'h01; tick();
        src_r = 8'h00; tick();
        src_r = 8'h01; tick();
        src_r = 8'h00; tick();
        rd(3'd4, 32'h1, "rp_overflow");
        rd(3'd3, 32'h1, "rp_inservice");
        eoi_r = 32'h0; tick();
        chk("rp_irq_fall", irq_o, 32'h0);
        tick();
        chk("rp_irq_fall1", irq_o, 32'h0);
        tick();
        chk("rp_irq_fall2", irq_o, 32'h8);
        wr(3'd4, 32'h1);
        rd(3'd4, 32'h0, "rp_ovf_clr");
        eoi_r = 32'h8; tick();
        eoi_r = 32'h0; tick();
        rd(3'd2, 32'h0, "rp_idle");

        // Level mode with masking on source 2.
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h0);
        src_r = 8'h04; tick();
        rd(3'd2, 32'h4, "lv_pending");
        chk("lv_masked", irq_o, 32'h0);
        wr(3'd0, 32'h4);
        tick();
        chk("lv_enabled", irq_o, 32'h20);
        eoi_r = 32'h20; tick();
        chk("lv_ack", irq_o, 32'h0);
        eoi_r = 32'h0; tick();
        rd(3'd2, 32'h0, "lv_idle_after_fall");
        rd(3'd2, 32'h4, "lv_repend");
        chk("lv_repend_irq", irq_o, 32'h20);
        src_r = 8'h00;
        eoi_r = 32'h20; tick();
        eoi_r = 32'h0; tick();

        // W1C racing a new edge on source 1.
        wr(3'd1, 32'h2);
        wr(3'd0, 32'h2);
        src_r = 8'h02; tick();
        src_r = 8'h00; tick();
        chk("race_pend_irq", irq_o, 32'h10);
        src_r = 8'h02; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 32'h2;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0; src_r = 8'h00;
        chk("race_irq", irq_o, 32'h10);
        rd(3'd2, 32'h2, "race_pending");
        wr(3'd2, 32'h2);
        chk("w1c_irq", irq_o, 32'h0);
        rd(3'd2, 32'h0, "w1c_pending");

        // Stray eoi bits, then reset during service.
        src_r = 8'h02; tick();
        src_r = 8'h00; tick();
        chk("stray_base", irq_o, 32'h10);
        eoi_r = 32'h7; tick();
        chk("stray_low", irq_o, 32'h10);
        eoi_r = 32'hFFFF_F800; tick();
        chk("stray_high", irq_o, 32'h10);
        eoi_r = 32'h0; tick();
        chk("stray_clear", irq_o, 32'h10);
        rd(3'd2, 32'h2, "stray_pending");
        rd(3'd3, 32'h0, "stray_insvc");
        eoi_r = 32'h10; tick();
        rd(3'd3, 32'h2, "svc_insvc");
        reset = 1'b1; tick();
        chk("rst_svc_irq", irq_o, 32'h0);
        chk("rst_svc_dbg", {16'h0, dbg_state}, 32'h0);
        reset = 1'b0; tick();
        eoi_r = 32'h0; tick();
        rd(3'd3, 32'h0, "rst_insvc");
        rd(3'd2, 32'h0, "rst_pending");
        rd(3'd0, 32'h0, "rst_enable");
        chk("rst_final_irq", irq_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
